// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// mem_bus_responder: memory-side responder for the multiplexed SysBus
// (ALE/nME/nOE/nWE), serving reads and writes from a word-addressed RAM.
// Revision: 1.0
// ============================================================================
module mem_bus_responder #(
    parameter int                DATA_W    = 16,
    parameter int                DEPTH     = 1024,
    parameter logic [DATA_W-1:0] BASE_ADDR = 16'h0000
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic [DATA_W-1:0] SysBusIn,
    output logic [DATA_W-1:0] SysBusOut,
    output logic              SysBusOe,
    input  logic              ALE,
    input  logic              nME,
    input  logic              nOE,
    input  logic              nWE,
    output logic              Hit,
    output logic              Busy,
    output logic              ProtoErr,
    input  logic              ErrClr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Window bounds held one bit wider so BASE_ADDR+DEPTH cannot wrap.
    localparam int unsigned      WIN_HI_INT = int'(BASE_ADDR) + DEPTH;
    localparam logic [DATA_W:0]  WIN_LO     = {1'b0, BASE_ADDR};
    localparam logic [DATA_W:0]  WIN_HI     = WIN_HI_INT[DATA_W:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              hit_q, hit_d;
    logic              proto_err_q, proto_err_d;

    logic [DATA_W-1:0] ram [DEPTH];
    logic              ram_we;
    logic [IDX_W-1:0]  idx;
    logic              violation;

    function automatic logic in_window(input logic [DATA_W-1:0] a);
        logic [DATA_W:0] av;
        av = {1'b0, a};
        return (av >= WIN_LO) && (av < WIN_HI);
    endfunction

    assign idx       = IDX_W'(addr_q - BASE_ADDR);
    assign violation = !nME && !nOE && !nWE;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rd_data_d   = rd_data_q;
        wr_data_d   = wr_data_q;
        hit_d       = hit_q;
        proto_err_d = proto_err_q;
        ram_we      = 1'b0;

        if (ErrClr) begin
            proto_err_d = 1'b0;
        end
        if (violation) begin
            proto_err_d = 1'b1;
        end

        if (ALE) begin
            // A new address phase flushes any write still pending at the old address.
            ram_we  = (state_q == ST_WRITE) && hit_q;
            addr_d  = SysBusIn;
            hit_d   = in_window(SysBusIn);
            state_d = ST_ADDR;
        end else if (violation) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (!nME && !nOE) begin
                        rd_data_d = hit_q ? ram[idx] : '0;
                        state_d   = ST_READ;
                    end else if (!nME && !nWE) begin
                        wr_data_d = SysBusIn;
                        state_d   = ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (nME && nOE) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (!nME && !nWE) begin
                        wr_data_d = SysBusIn;
                    end else begin
                        ram_we  = hit_q;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rd_data_q   <= '0;
            wr_data_q   <= '0;
            hit_q       <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_data_q   <= rd_data_d;
            wr_data_q   <= wr_data_d;
            hit_q       <= hit_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (ram_we) begin
            ram[idx] <= wr_data_q;
        end
    end

    assign SysBusOe  = (state_q == ST_READ) && !nOE && hit_q;
    assign SysBusOut = SysBusOe ? rd_data_q : '0;
    assign Hit       = hit_q;
    assign Busy      = (state_q != ST_IDLE);
    assign ProtoErr  = proto_err_q;

endmodule
`default_nettype wire
